// File: rtl/pll_freq_ctrl_pkg.sv
// Shared FSM state type and saturating trim helpers for the PLL frequency-lock controller.
package pll_freq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_EVAL    = 2'd2
    } state_t;

    // Mid-scale trim code, so a freshly enabled channel can move either way.
    function automatic int unsigned trim_init(input int unsigned trim_w);
        return 32'd1 << (trim_w - 1);
    endfunction

    function automatic int unsigned sat_inc(input int unsigned value, input int unsigned max_value);
        return (value >= max_value) ? max_value : value + 1;
    endfunction

    function automatic int unsigned sat_dec(input int unsigned value);
        return (value == 0) ? 0 : value - 1;
    endfunction

endpackage

// File: rtl/pll_edge_sync.sv
// Two-flop synchronizer for one divided VCO line plus a registered rising-edge pulse.
module pll_edge_sync
    import pll_freq_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic sync_3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
            pulse  <= 1'b0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
            pulse  <= sync_2 & ~sync_3;
        end
    end

endmodule

// File: rtl/pll_freq_ctrl.sv
// Round-robin frequency-lock controller for N_CH PLL channels: count edges per window, trim, lock.
// Optional lock-loss interrupt (irq_clr_i / irq_o) is built when PLL_FREQ_CTRL_LOSS_IRQ_EN is defined.
module pll_freq_ctrl
    import pll_freq_ctrl_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 12,
    parameter int WIN_W  = 16,
    parameter int TRIM_W = 6,
    parameter int LOCK_N = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_ni,
    input  logic [N_CH-1:0]          en_i,
    input  logic [N_CH-1:0]          vco_div_i,
    input  logic [N_CH*CNT_W-1:0]    target_i,
    input  logic [CNT_W-1:0]         tol_i,
    input  logic [WIN_W-1:0]         window_i,
`ifdef PLL_FREQ_CTRL_LOSS_IRQ_EN
    input  logic                     irq_clr_i,
    output logic                     irq_o,
`endif
    output logic [N_CH-1:0]          enb_vco_o,
    output logic [N_CH-1:0]          enb_cp_o,
    output logic [N_CH*TRIM_W-1:0]   trim_o,
    output logic [N_CH-1:0]          lock_o,
    output logic                     busy_o
);

    localparam int                CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [TRIM_W-1:0] TRIM_INIT = TRIM_W'(trim_init(TRIM_W));
    localparam int unsigned       TRIM_MAX  = (1 << TRIM_W) - 1;
    localparam logic [3:0]        LOCK_MAX  = 4'(LOCK_N);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(N_CH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CH_W-1:0]   ch_ptr;
    logic [CH_W-1:0]   ch_sel;
    logic [CH_W-1:0]   ch_pick;
    logic [CH_W-1:0]   ch_after;
    logic              ch_found;
    logic [WIN_W-1:0]  win_cnt;
    logic [CNT_W-1:0]  edge_cnt;
    logic [CNT_W-1:0]  tgt_sel;
    logic [N_CH-1:0]   edge_pulse;
    logic              sel_en;
    logic              too_low;
    logic              too_high;
    logic [TRIM_W-1:0] trim_q [N_CH];
    logic [3:0]        lock_cnt [N_CH];

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        pll_edge_sync u_edge_sync (
            .clk   (wb_clk_i),
            .rst_n (wb_rst_ni),
            .din   (vco_div_i[c]),
            .pulse (edge_pulse[c])
        );
        assign trim_o[c*TRIM_W +: TRIM_W] = trim_q[c];
    end

    assign busy_o   = (state != ST_IDLE);
    assign sel_en   = en_i[ch_sel];
    assign tgt_sel  = target_i[ch_sel*CNT_W +: CNT_W];
    assign ch_after = (ch_sel == LAST_CH) ? '0 : ch_sel + 1'b1;
    // Unsigned form of |edge_cnt - target| > tol, split by sign of the difference.
    assign too_low  = (edge_cnt < tgt_sel) && ((tgt_sel - edge_cnt) > tol_i);
    assign too_high = (edge_cnt > tgt_sel) && ((edge_cnt - tgt_sel) > tol_i);

    // Lowest enabled channel at or above ch_ptr, wrapping past the last one.
    always_comb begin
        ch_found = 1'b0;
        ch_pick  = ch_ptr;
        for (int i = 0; i < N_CH; i++) begin
            if (!ch_found && en_i[(int'(ch_ptr) + i) % N_CH]) begin
                ch_found = 1'b1;
                ch_pick  = CH_W'((int'(ch_ptr) + i) % N_CH);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (ch_found) state_nxt = ST_MEASURE;
            ST_MEASURE: begin
                if (!sel_en)              state_nxt = ST_IDLE;
                else if (win_cnt == '0)   state_nxt = ST_EVAL;
            end
            ST_EVAL:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= ST_IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ch_ptr   <= '0;
            ch_sel   <= '0;
            win_cnt  <= '0;
            edge_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ch_found) begin
                        ch_sel   <= ch_pick;
                        win_cnt  <= window_i;
                        edge_cnt <= '0;
                    end
                end
                ST_MEASURE: begin
                    if (!sel_en) begin
                        ch_ptr <= ch_after;
                    end else begin
                        win_cnt <= win_cnt - 1'b1;
                        if (edge_pulse[ch_sel] && (edge_cnt != '1)) edge_cnt <= edge_cnt + 1'b1;
                    end
                end
                ST_EVAL: ch_ptr <= ch_after;
                default: ;
            endcase
        end
    end

    // A disabled channel is forced back to its idle values ahead of any evaluation.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            enb_vco_o <= '1;
            enb_cp_o  <= '1;
            lock_o    <= '0;
            for (int c = 0; c < N_CH; c++) begin
                trim_q[c]   <= TRIM_INIT;
                lock_cnt[c] <= '0;
            end
        end else begin
            enb_vco_o <= ~en_i;
            for (int c = 0; c < N_CH; c++) begin
                if (!en_i[c]) begin
                    trim_q[c]   <= TRIM_INIT;
                    lock_cnt[c] <= '0;
                    lock_o[c]   <= 1'b0;
                    enb_cp_o[c] <= 1'b1;
                end else if ((state == ST_EVAL) && (int'(ch_sel) == c)) begin
                    if (edge_cnt != '0) enb_cp_o[c] <= 1'b0;
                    if (too_low) begin
                        trim_q[c]   <= TRIM_W'(sat_inc(32'(trim_q[c]), TRIM_MAX));
                        lock_cnt[c] <= '0;
                        lock_o[c]   <= 1'b0;
                    end else if (too_high) begin
                        trim_q[c]   <= TRIM_W'(sat_dec(32'(trim_q[c])));
                        lock_cnt[c] <= '0;
                        lock_o[c]   <= 1'b0;
                    end else begin
                        if (lock_cnt[c] != LOCK_MAX) lock_cnt[c] <= lock_cnt[c] + 1'b1;
                        if (lock_cnt[c] >= LOCK_MAX - 4'd1) lock_o[c] <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef PLL_FREQ_CTRL_LOSS_IRQ_EN
    logic lock_lost;

    assign lock_lost = (state == ST_EVAL) && sel_en && lock_o[ch_sel] && (too_low || too_high);

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)     irq_o <= 1'b0;
        else if (lock_lost) irq_o <= 1'b1;
        else if (irq_clr_i) irq_o <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_pll_freq_ctrl.sv
// Directed bench for pll_freq_ctrl with two channels: vector table plus multi-cycle corner sequences.
module tb_pll_freq_ctrl;

    localparam int N_CH   = 2;
    localparam int CNT_W  = 12;
    localparam int WIN_W  = 16;
    localparam int TRIM_W = 6;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH-1:0]        en;
    logic [N_CH-1:0]        vco = '0;
    logic [N_CH*CNT_W-1:0]  target;
    logic [CNT_W-1:0]       tol;
    logic [WIN_W-1:0]       window;
    logic [N_CH-1:0]        enb_vco;
    logic [N_CH-1:0]        enb_cp;
    logic [N_CH*TRIM_W-1:0] trim;
    logic [N_CH-1:0]        lock;
    logic                   busy;
`ifdef PLL_FREQ_CTRL_LOSS_IRQ_EN
    logic                   irq_clr;
    logic                   irq;
`endif

    int checks = 0;
    int errors = 0;
    int half_p [N_CH] = '{2, 2};
    int vcnt [N_CH]   = '{0, 0};

    typedef struct {
        string      name;
        logic [1:0] en;
        int         t0;
        int         t1;
        int         tol;
        int         win;
        int         n_eval;
        logic [5:0] e_trim0;
        logic [5:0] e_trim1;
        logic [1:0] e_lock;
        logic [1:0] e_cp;
        logic [1:0] e_vco;
    } vec_t;

    vec_t vq[$];

    pll_freq_ctrl #(
        .N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .TRIM_W(TRIM_W), .LOCK_N(4)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .en_i      (en),
        .vco_div_i (vco),
        .target_i  (target),
        .tol_i     (tol),
        .window_i  (window),
`ifdef PLL_FREQ_CTRL_LOSS_IRQ_EN
        .irq_clr_i (irq_clr),
        .irq_o     (irq),
`endif
        .enb_vco_o (enb_vco),
        .enb_cp_o  (enb_cp),
        .trim_o    (trim),
        .lock_o    (lock),
        .busy_o    (busy)
    );

    always #5 clk = ~clk;

    // Divided VCO model: each channel toggles every half_p falling edges.
    always @(negedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            vcnt[c] = vcnt[c] + 1;
            if (vcnt[c] >= half_p[c]) begin
                vcnt[c] = 0;
                vco[c]  = ~vco[c];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        en    = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int t0, input int t1, input int tl, input int win);
        target = {CNT_W'(t1), CNT_W'(t0)};
        tol    = CNT_W'(tl);
        window = WIN_W'(win);
    endtask

    // Counts busy falling edges; each one marks an evaluation finishing in these tests.
    task automatic wait_evals(input int n, input string tag);
        int   seen;
        int   cyc;
        int   budget;
        logic prev;
        seen   = 0;
        cyc    = 0;
        budget = (n + 1) * (int'(window) + 10);
        prev   = busy;
        while (seen < n && cyc < budget) begin
            @(posedge clk);
            #1;
            if (prev && !busy) seen++;
            prev = busy;
            cyc++;
        end
        check({tag, "/evals_seen"}, 32'(seen), 32'(n));
    endtask

    task automatic wait_busy_rise(input string tag);
        int cyc;
        cyc = 0;
        while (!busy && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "/busy_rise"}, 32'(busy), 32'd1);
    endtask

    task automatic add_vec(input string name, input logic [1:0] e, input int t0, input int t1,
                           input int tl, input int win, input int n, input logic [5:0] tr0,
                           input logic [5:0] tr1, input logic [1:0] lk, input logic [1:0] cp,
                           input logic [1:0] vc);
        vec_t v;
        v.name = name; v.en = e; v.t0 = t0; v.t1 = t1; v.tol = tl; v.win = win; v.n_eval = n;
        v.e_trim0 = tr0; v.e_trim1 = tr1; v.e_lock = lk; v.e_cp = cp; v.e_vco = vc;
        vq.push_back(v);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = '0;
        target = '0;
        tol    = '0;
        window = '0;
`ifdef PLL_FREQ_CTRL_LOSS_IRQ_EN
        irq_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset/trim", 32'(trim), 32'({6'd32, 6'd32}));
        check("reset/lock", 32'(lock), 32'd0);
        check("reset/enb_vco", 32'(enb_vco), 32'd3);
        check("reset/enb_cp", 32'(enb_cp), 32'd3);
        check("reset/busy", 32'(busy), 32'd0);
`ifdef PLL_FREQ_CTRL_LOSS_IRQ_EN
        check("reset/irq", 32'(irq), 32'd0);
`endif

        // 25 edges per 100-cycle window with a period-4 divided clock.
        add_vec("lock3",    2'b01, 25, 25, 1,  99, 3, 6'd32, 6'd32, 2'b00, 2'b10, 2'b10);
        add_vec("lock4",    2'b01, 25, 25, 1,  99, 4, 6'd32, 6'd32, 2'b01, 2'b10, 2'b10);
        add_vec("up3",      2'b01, 40, 25, 1,  99, 3, 6'd35, 6'd32, 2'b00, 2'b10, 2'b10);
        add_vec("tol_in",   2'b01, 26, 25, 1,  99, 4, 6'd32, 6'd32, 2'b01, 2'b10, 2'b10);
        add_vec("tol_out",  2'b01, 27, 25, 1,  99, 2, 6'd34, 6'd32, 2'b00, 2'b10, 2'b10);
        add_vec("down2",    2'b01, 23, 25, 1,  99, 2, 6'd30, 6'd32, 2'b00, 2'b10, 2'b10);
        add_vec("tol0",     2'b01, 25, 25, 0,  99, 4, 6'd32, 6'd32, 2'b01, 2'b10, 2'b10);
        add_vec("win199",   2'b01, 50, 25, 0, 199, 4, 6'd32, 6'd32, 2'b01, 2'b10, 2'b10);
        add_vec("both7",    2'b11, 25, 25, 1,  99, 7, 6'd32, 6'd32, 2'b01, 2'b00, 2'b00);
        add_vec("both8",    2'b11, 25, 25, 1,  99, 8, 6'd32, 6'd32, 2'b11, 2'b00, 2'b00);
        add_vec("mixed",    2'b11, 40, 10, 1,  99, 4, 6'd34, 6'd30, 2'b00, 2'b00, 2'b00);
        add_vec("idle",     2'b00, 25, 25, 1,  99, 0, 6'd32, 6'd32, 2'b00, 2'b11, 2'b11);
        add_vec("ch1only",  2'b10, 25, 25, 1,  99, 4, 6'd32, 6'd32, 2'b10, 2'b01, 2'b01);

        for (int i = 0; i < vq.size(); i++) begin
            do_reset();
            set_cfg(vq[i].t0, vq[i].t1, vq[i].tol, vq[i].win);
            en = vq[i].en;
            if (vq[i].n_eval > 0) begin
                wait_evals(vq[i].n_eval, vq[i].name);
            end else begin
                repeat (20) @(posedge clk);
                #1;
                check({vq[i].name, "/busy"}, 32'(busy), 32'd0);
            end
            check({vq[i].name, "/trim0"}, 32'(trim[5:0]), 32'(vq[i].e_trim0));
            check({vq[i].name, "/trim1"}, 32'(trim[11:6]), 32'(vq[i].e_trim1));
            check({vq[i].name, "/lock"}, 32'(lock), 32'(vq[i].e_lock));
            check({vq[i].name, "/enb_cp"}, 32'(enb_cp), 32'(vq[i].e_cp));
            check({vq[i].name, "/enb_vco"}, 32'(enb_vco), 32'(vq[i].e_vco));
        end

        // enb_vco follows ~en with exactly one cycle of latency.
        do_reset();
        set_cfg(25, 25, 1, 99);
        en = 2'b01;
        #1 check("vco_lat/before", 32'(enb_vco), 32'd3);
        @(posedge clk);
        #1 check("vco_lat/after", 32'(enb_vco), 32'd2);
        check("vco_lat/cp_before_eval", 32'(enb_cp), 32'd3);

        // Trim saturates at 0 and at 63 without wrapping.
        do_reset();
        set_cfg(10, 25, 1, 99);
        en = 2'b01;
        wait_evals(34, "trim_floor");
        check("trim_floor/trim0", 32'(trim[5:0]), 32'd0);
        do_reset();
        set_cfg(40, 25, 1, 99);
        en = 2'b01;
        wait_evals(33, "trim_ceil");
        check("trim_ceil/trim0", 32'(trim[5:0]), 32'd63);

        // Abort of ch0 mid-window; ch1 is serviced next.
        do_reset();
        set_cfg(40, 40, 1, 99);
        en = 2'b11;
        wait_evals(2, "abort");
        check("abort/trims_pre", 32'(trim), 32'({6'd33, 6'd33}));
        repeat (20) @(posedge clk);
        #1;
        check("abort/busy_pre", 32'(busy), 32'd1);
        check("abort/cp_pre", 32'(enb_cp), 32'd0);
        en = 2'b10;
        @(posedge clk);
        #1;
        check("abort/busy", 32'(busy), 32'd0);
        check("abort/trim0", 32'(trim[5:0]), 32'd32);
        check("abort/lock", 32'(lock), 32'd0);
        check("abort/enb_vco", 32'(enb_vco), 32'd1);
        check("abort/enb_cp", 32'(enb_cp), 32'd1);
        wait_evals(1, "abort_next");
        check("abort_next/trim1", 32'(trim[11:6]), 32'd34);
        check("abort_next/trim0", 32'(trim[5:0]), 32'd32);

        // Disable lands on the evaluation cycle: the disable must win.
        do_reset();
        set_cfg(40, 25, 1, 99);
        en = 2'b01;
        wait_busy_rise("dis_eval");
        repeat (100) @(posedge clk);
        #1;
        check("dis_eval/busy_in_eval", 32'(busy), 32'd1);
        en = 2'b00;
        @(posedge clk);
        #1;
        check("dis_eval/trim0", 32'(trim[5:0]), 32'd32);
        check("dis_eval/enb_cp", 32'(enb_cp), 32'd3);
        check("dis_eval/busy", 32'(busy), 32'd0);

        // Edge counter saturates at 4095: 5000 edges against target 4000 must lower the trim.
        do_reset();
        half_p[0] = 1;
        set_cfg(4000, 25, 1, 9999);
        en = 2'b01;
        wait_evals(1, "cnt_sat");
        check("cnt_sat/trim0", 32'(trim[5:0]), 32'd31);
        check("cnt_sat/lock", 32'(lock), 32'd0);
        half_p[0] = 2;

`ifdef PLL_FREQ_CTRL_LOSS_IRQ_EN
        do_reset();
        set_cfg(25, 25, 1, 99);
        en = 2'b01;
        wait_evals(4, "irq_lock");
        check("irq/locked", 32'(lock), 32'd1);
        check("irq/idle", 32'(irq), 32'd0);
        set_cfg(40, 25, 1, 99);
        wait_evals(1, "irq_loss");
        check("irq/lock_dropped", 32'(lock), 32'd0);
        @(posedge clk);
        #1 check("irq/set", 32'(irq), 32'd1);
        irq_clr = 1'b1;
        @(posedge clk);
        #1 irq_clr = 1'b0;
        check("irq/cleared", 32'(irq), 32'd0);
        set_cfg(25, 25, 1, 99);
        wait_evals(5, "irq_relock");
        check("irq/relocked", 32'(lock), 32'd1);
        en = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("irq/dis_lock", 32'(lock), 32'd0);
        check("irq/dis_no_set", 32'(irq), 32'd0);
`endif

        // Asynchronous reset in the middle of a window.
        do_reset();
        set_cfg(40, 25, 1, 99);
        en = 2'b01;
        wait_evals(1, "async_rst");
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst/trim", 32'(trim), 32'({6'd32, 6'd32}));
        check("async_rst/lock", 32'(lock), 32'd0);
        check("async_rst/enb_vco", 32'(enb_vco), 32'd3);
        check("async_rst/enb_cp", 32'(enb_cp), 32'd3);
        check("async_rst/busy", 32'(busy), 32'd0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
